li_param_fifo: RTL and testbench

//  Generalised synchronous FIFO for latency-insensitive shells. It replaces the vendor-megafunction

---
 rtl/li_fifo_pkg.sv | 20 ++
 rtl/li_fifo_mem.sv | 32 +++
 rtl/li_param_fifo.sv | 140 ++++++++++++++
 tb/tb_li_param_fifo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/li_fifo_pkg.sv
// Shared sizing helpers and read-mode constants for the latency-insensitive FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a (compile-time only).
package li_fifo_pkg;

    // Read-mode selectors for the SHOWAHEAD parameter
    localparam int LI_FIFO_NORMAL    = 0;
    localparam int LI_FIFO_SHOWAHEAD = 1;

    // Number of words held by a FIFO with the given address width
    function automatic int fifo_depth(input int addr);
        return 1 << addr;
    endfunction

    // Occupancy counter width: one extra bit so that a completely full FIFO is representable
    function automatic int usedw_width(input int addr);
        return addr + 1;
    endfunction

endpackage

// File: rtl/li_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read data is combinational from rd_addr.
// Backpressure: none; the owner decides when a write is allowed.
module li_fifo_mem
    import li_fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ADDR  = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ADDR-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [ADDR-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR);

    // Storage is deliberately left uninitialised; occupancy tracking makes stale words invisible.
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: a same-cycle read of this slot still sees the old word (read-before-write).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/li_param_fifo.sv
// Parameterised synchronous FIFO for latency-insensitive shell input queues.
// Latency: normal mode data one cycle after deq; show-ahead head visible the cycle after the write.
// Backpressure: enq while full is dropped unless a deq is accepted in the same cycle; errors are sticky.
module li_param_fifo
    import li_fifo_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ADDR        = 2,
    parameter int ALMOST_FULL = 3,
    parameter int SHOWAHEAD   = LI_FIFO_NORMAL
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            i_data,
    input  logic                        i_enq,
    input  logic                        i_deq,
    output logic [WIDTH-1:0]            o_data,
    output logic [usedw_width(ADDR)-1:0] o_usedw,
    output logic                        o_almost_full,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_overflow,
    output logic                        o_underflow
);

    localparam int DEPTH = fifo_depth(ADDR);
    localparam int UW    = usedw_width(ADDR);

    localparam logic [UW-1:0] DEPTH_LVL = UW'(DEPTH);
    localparam logic [UW-1:0] AF_LVL    = UW'(ALMOST_FULL);

    // Reject illegal configurations at elaboration time rather than building a broken FIFO.
    if (WIDTH < 1) begin : g_bad_width
        $error("li_param_fifo: WIDTH must be >= 1");
    end
    if (ADDR < 1) begin : g_bad_addr
        $error("li_param_fifo: ADDR must be >= 1");
    end
    if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_af
        $error("li_param_fifo: ALMOST_FULL must be within 1..DEPTH");
    end
    if (SHOWAHEAD != LI_FIFO_NORMAL && SHOWAHEAD != LI_FIFO_SHOWAHEAD) begin : g_bad_mode
        $error("li_param_fifo: SHOWAHEAD must be 0 or 1");
    end

    logic [ADDR-1:0]  wr_ptr;
    logic [ADDR-1:0]  rd_ptr;
    logic [UW-1:0]    usedw_q;
    logic [UW-1:0]    usedw_d;
    logic             overflow_q;
    logic             underflow_q;
    logic             deq_ok;
    logic             enq_ok;
    logic [WIDTH-1:0] rd_word;

    // Status flags all decode the registered count, so they trail the request by one cycle.
    assign o_usedw       = usedw_q;
    assign o_empty       = (usedw_q == '0);
    assign o_full        = (usedw_q == DEPTH_LVL);
    assign o_almost_full = (usedw_q >= AF_LVL);
    assign o_overflow    = overflow_q;
    assign o_underflow   = underflow_q;

    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign deq_ok = i_deq & ~o_empty;
    assign enq_ok = i_enq & (~o_full | deq_ok);

    // Occupancy next-state: simultaneous enq and deq leave the count unchanged.
    always_comb begin
        usedw_d = usedw_q;
        case ({enq_ok, deq_ok})
            2'b10:   usedw_d = usedw_q + UW'(1);
            2'b01:   usedw_d = usedw_q - UW'(1);
            default: usedw_d = usedw_q;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            usedw_q <= '0;
        end else begin
            usedw_q <= usedw_d;
            if (enq_ok) begin
                wr_ptr <= wr_ptr + ADDR'(1);
            end
            if (deq_ok) begin
                rd_ptr <= rd_ptr + ADDR'(1);
            end
        end
    end

    // Sticky protocol-error flags; they only record misuse and never gate the datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (i_enq && o_full && !deq_ok) begin
                overflow_q <= 1'b1;
            end
            if (i_deq && o_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    li_fifo_mem #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR)
    ) u_mem (
        .clk     (clk),
        .wr_en   (enq_ok),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    if (SHOWAHEAD == LI_FIFO_SHOWAHEAD) begin : g_showahead
        // Head word is presented directly; meaningless while the FIFO is empty.
        assign o_data = rd_word;
    end else begin : g_normal
        logic [WIDTH-1:0] data_q;

        // Capture the head on an accepted deq; hold through idle cycles and rejected deqs.
        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
            end else if (deq_ok) begin
                data_q <= rd_word;
            end
        end

        assign o_data = data_q;
    end

endmodule

// File: tb/tb_li_param_fifo.sv
// Directed bench for li_param_fifo: normal-mode and show-ahead instances on one clock.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next edge.
// Backpressure: exercised via full/empty corner cases and a randomised scoreboard run.
module tb_li_param_fifo;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] n_din;
    logic        n_enq;
    logic        n_deq;
    logic [15:0] n_dout;
    logic [2:0]  n_usedw;
    logic        n_af, n_full, n_empty, n_ovf, n_unf;

    logic [15:0] s_din;
    logic        s_enq;
    logic        s_deq;
    logic [15:0] s_dout;
    logic [2:0]  s_usedw;
    logic        s_af, s_full, s_empty, s_ovf, s_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    li_param_fifo #(
        .WIDTH       (16),
        .ADDR        (2),
        .ALMOST_FULL (3),
        .SHOWAHEAD   (0)
    ) u_norm (
        .clk           (clk),
        .reset         (reset),
        .i_data        (n_din),
        .i_enq         (n_enq),
        .i_deq         (n_deq),
        .o_data        (n_dout),
        .o_usedw       (n_usedw),
        .o_almost_full (n_af),
        .o_full        (n_full),
        .o_empty       (n_empty),
        .o_overflow    (n_ovf),
        .o_underflow   (n_unf)
    );

    li_param_fifo #(
        .WIDTH       (16),
        .ADDR        (2),
        .ALMOST_FULL (4),
        .SHOWAHEAD   (1)
    ) u_show (
        .clk           (clk),
        .reset         (reset),
        .i_data        (s_din),
        .i_enq         (s_enq),
        .i_deq         (s_deq),
        .o_data        (s_dout),
        .o_usedw       (s_usedw),
        .o_almost_full (s_af),
        .o_full        (s_full),
        .o_empty       (s_empty),
        .o_overflow    (s_ovf),
        .o_underflow   (s_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1ns past the edge, where outputs are stable.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic n_drive(input logic enq, input logic deq, input logic [15:0] d);
        n_enq = enq;
        n_deq = deq;
        n_din = d;
    endtask

    task automatic s_drive(input logic enq, input logic deq, input logic [15:0] d);
        s_enq = enq;
        s_deq = deq;
        s_din = d;
    endtask

    logic [15:0] sb[$];
    logic [15:0] last_out;
    logic [15:0] rnd_d;
    logic        e, d, eo, dq;

    initial begin
        reset = 1'b1;
        n_drive(1'b0, 1'b0, 16'h0);
        s_drive(1'b0, 1'b0, 16'h0);
        #1;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state
        check("rst_usedw", n_usedw, 0);
        check("rst_empty", n_empty, 1);
        check("rst_full", n_full, 0);
        check("rst_af", n_af, 0);
        check("rst_ovf", n_ovf, 0);
        check("rst_unf", n_unf, 0);
        check("rst_data", n_dout, 0);
        check("rst_s_empty", s_empty, 1);

        // 1: fill with A1..A4, watching the count and threshold flags
        n_drive(1, 0, 16'hA1); cyc();
        check("t1_usedw1", n_usedw, 1);
        check("t1_empty1", n_empty, 0);
        n_drive(1, 0, 16'hA2); cyc();
        check("t1_usedw2", n_usedw, 2);
        check("t1_af2", n_af, 0);
        n_drive(1, 0, 16'hA3); cyc();
        check("t1_usedw3", n_usedw, 3);
        check("t1_af3", n_af, 1);
        check("t1_full3", n_full, 0);
        n_drive(1, 0, 16'hA4); cyc();
        check("t1_usedw4", n_usedw, 4);
        check("t1_full4", n_full, 1);

        // 1: drain, each word one cycle after its deq
        n_drive(0, 1, 16'h0); cyc();
        check("t1_deq_a1", n_dout, 16'hA1);
        check("t1_deq_usedw3", n_usedw, 3);
        check("t1_deq_full", n_full, 0);
        cyc();
        check("t1_deq_a2", n_dout, 16'hA2);
        check("t1_deq_af2", n_af, 0);
        cyc();
        check("t1_deq_a3", n_dout, 16'hA3);
        cyc();
        check("t1_deq_a4", n_dout, 16'hA4);
        check("t1_deq_empty", n_empty, 1);
        n_drive(0, 0, 16'h0); cyc();
        check("t1_hold_a4", n_dout, 16'hA4);

        // 2: refill, then simultaneous enq+deq while full (read-before-write on slot 0)
        n_drive(1, 0, 16'hA1); cyc();
        n_drive(1, 0, 16'hA2); cyc();
        n_drive(1, 0, 16'hA3); cyc();
        n_drive(1, 0, 16'hA4); cyc();
        check("t2_full", n_full, 1);
        n_drive(1, 1, 16'hB5); cyc();
        check("t2_rbw_data", n_dout, 16'hA1);
        check("t2_rbw_usedw", n_usedw, 4);
        check("t2_rbw_ovf", n_ovf, 0);
        n_drive(1, 0, 16'hC6); cyc();
        check("t2_ovf_usedw", n_usedw, 4);
        check("t2_ovf_set", n_ovf, 1);
        n_drive(0, 0, 16'h0); cyc();
        check("t2_ovf_sticky", n_ovf, 1);
        n_drive(0, 1, 16'h0); cyc();
        check("t2_drain_a2", n_dout, 16'hA2);
        cyc();
        check("t2_drain_a3", n_dout, 16'hA3);
        cyc();
        check("t2_drain_a4", n_dout, 16'hA4);
        cyc();
        check("t2_drain_b5", n_dout, 16'hB5);
        check("t2_drain_empty", n_empty, 1);
        check("t2_ovf_still", n_ovf, 1);

        // 3: deq on empty, then enq+deq together on empty
        n_drive(0, 1, 16'h0); cyc();
        check("t3_unf", n_unf, 1);
        check("t3_usedw0", n_usedw, 0);
        check("t3_data_hold", n_dout, 16'hB5);
        n_drive(1, 1, 16'hD7); cyc();
        check("t3_both_usedw", n_usedw, 1);
        check("t3_both_data", n_dout, 16'hB5);
        n_drive(0, 1, 16'h0); cyc();
        check("t3_retained", n_dout, 16'hD7);
        check("t3_empty", n_empty, 1);
        check("t3_unf_sticky", n_unf, 1);

        // 5: randomised interleaving with a queue scoreboard
        n_drive(0, 0, 16'h0); cyc();
        last_out = 16'hD7;
        for (int i = 0; i < 40; i++) begin
            e     = 1'($urandom_range(0, 1));
            d     = 1'($urandom_range(0, 1));
            rnd_d = 16'($urandom);
            dq = d && (sb.size() > 0);
            eo = e && ((sb.size() < 4) || dq);
            if (dq) last_out = sb.pop_front();
            if (eo) sb.push_back(rnd_d);
            n_drive(e, d, rnd_d); cyc();
            check("t5_usedw", n_usedw, sb.size());
            check("t5_data", n_dout, last_out);
            check("t5_range", (n_usedw <= 3'd4), 1);
        end
        n_drive(0, 0, 16'h0);

        // 4: show-ahead instance, ALMOST_FULL == DEPTH
        s_drive(1, 0, 16'h0055); cyc();
        check("t4_s_empty", s_empty, 0);
        check("t4_s_data55", s_dout, 16'h0055);
        check("t4_s_af1", s_af, 0);
        s_drive(0, 0, 16'h0); cyc();
        check("t4_s_hold55", s_dout, 16'h0055);
        s_drive(1, 0, 16'h0066); cyc();
        s_drive(1, 0, 16'h0077); cyc();
        check("t4_s_af3", s_af, 0);
        s_drive(1, 0, 16'h0088); cyc();
        check("t4_s_usedw4", s_usedw, 4);
        check("t4_s_af4", s_af, 1);
        check("t4_s_full4", s_full, 1);
        check("t4_s_head", s_dout, 16'h0055);
        s_drive(0, 1, 16'h0); cyc();
        check("t4_s_data66", s_dout, 16'h0066);
        check("t4_s_af_drop", s_af, 0);
        cyc();
        check("t4_s_data77", s_dout, 16'h0077);
        cyc();
        check("t4_s_data88", s_dout, 16'h0088);
        cyc();
        check("t4_s_empty_end", s_empty, 1);
        s_drive(0, 0, 16'h0);

        // 6: reset mid-traffic with an enq pending
        reset = 1'b1; cyc();
        reset = 1'b0;
        n_drive(1, 0, 16'h00E1); cyc();
        n_drive(1, 0, 16'h00E2); cyc();
        n_drive(1, 0, 16'h00E3); cyc();
        check("t6_usedw3", n_usedw, 3);
        reset = 1'b1;
        n_drive(1, 0, 16'h00E4); cyc();
        check("t6_usedw0", n_usedw, 0);
        check("t6_empty", n_empty, 1);
        check("t6_ovf", n_ovf, 0);
        check("t6_unf", n_unf, 0);
        check("t6_data", n_dout, 0);
        reset = 1'b0;
        n_drive(0, 1, 16'h0); cyc();
        check("t6_enq_ignored", n_dout, 0);
        check("t6_unf_after", n_unf, 1);
        n_drive(0, 0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
